// File: rtl/issue_queue_m2_pkg.sv
// Shared types for the issue stage: execution-unit indices and the default buffer entry layout.
// Pure declarations; no timing or backpressure of its own.
package Types_m1;

  localparam int UNIT_ALU  = 0;
  localparam int UNIT_MUL  = 1;
  localparam int UNIT_DIV  = 2;
  localparam int UNIT_BRH  = 3;
  localparam int UNIT_LSU  = 4;
  localparam int NUM_UNITS = UNIT_LSU + 1;

  localparam int IQ_AW = 4;
  localparam int IQ_UW = $clog2(NUM_UNITS);
  localparam int IQ_PW = 32;

  typedef struct packed {
    logic [IQ_AW-1:0] dest;
    logic [IQ_AW-1:0] src1;
    logic [IQ_AW-1:0] src2;
    logic             dest_used;
    logic             src1_used;
    logic             src2_used;
    logic             fence;
    logic [IQ_UW-1:0] unit;
    logic [IQ_PW-1:0] payload;
  } iq_entry_t;

endpackage

// File: rtl/issue_queue_m2_fifo.sv
// Circular issue buffer: push at tail, pop at head, flush empties it.
// Head entry readable the cycle after the push edge; full is a pure function of registered count.
// Caller must gate push with !full and pop with count != 0.
module issue_fifo_m2
  import Types_m1::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = iq_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;

  entry_t            mem [DEPTH];
  logic [PTRW-1:0]   head_ptr;
  logic [PTRW-1:0]   tail_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only read behind a nonzero count.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_data;
  end

  assign head_data = mem[head_ptr];
  assign full      = (count == CW'(DEPTH));

endmodule

// File: rtl/issue_queue_m2.sv
// In-order issue stage: buffered micro-ops released from the head against a register scoreboard.
// Enqueue at edge t can fire at t+1 at the earliest; one issue per cycle when hazard-free.
// in_ready drops when the buffer is full; the head waits on hazards, unit_ready and fence draining.
module issue_queue_m2
  import Types_m1::*;
#(
  parameter int AW     = 4,
  parameter int DEPTH  = 4,
  parameter int NWB    = 2,
  parameter int NUNITS = NUM_UNITS,
  parameter int PW     = 32,
  localparam int NREGS = 2 ** AW,
  localparam int UW    = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_dest,
  input  logic [AW-1:0]          in_src1,
  input  logic [AW-1:0]          in_src2,
  input  logic                   in_dest_used,
  input  logic                   in_src1_used,
  input  logic                   in_src2_used,
  input  logic                   in_fence,
  input  logic [UW-1:0]          in_unit,
  input  logic [PW-1:0]          in_payload,
  input  logic [NWB-1:0]         wb_valid,
  input  logic [NWB*AW-1:0]      wb_addr,
  input  logic [NUNITS-1:0]      unit_ready,
  input  logic                   exe_idle,
  output logic                   out_valid,
  output logic [UW-1:0]          out_unit,
  output logic [AW-1:0]          out_dest,
  output logic [AW-1:0]          out_src1,
  output logic [AW-1:0]          out_src2,
  output logic [PW-1:0]          out_payload,
  output logic                   out_dest_used,
  output logic [NREGS-1:0]       sb_busy,
  output logic [$clog2(DEPTH):0] count
);

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [AW-1:0] src1;
    logic [AW-1:0] src2;
    logic          dest_used;
    logic          src1_used;
    logic          src2_used;
    logic          fence;
    logic [UW-1:0] unit;
    logic [PW-1:0] payload;
  } entry_t;

  entry_t           in_entry;
  entry_t           head;
  logic             push;
  logic             fire;
  logic             full;
  logic [NREGS-1:0] clr;
  logic [NREGS-1:0] eff_busy;
  logic [NREGS-1:0] set_vec;
  logic             src1_ok;
  logic             src2_ok;
  logic             dest_ok;
  logic             unit_ok;
  logic             fence_ok;

  assign in_entry = '{dest: in_dest, src1: in_src1, src2: in_src2,
                      dest_used: in_dest_used, src1_used: in_src1_used,
                      src2_used: in_src2_used, fence: in_fence,
                      unit: in_unit, payload: in_payload};

  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;

  issue_fifo_m2 #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (in_entry),
    .pop       (fire),
    .head_data (head),
    .count     (count),
    .full      (full)
  );

  always_comb begin
    clr = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int k = 0; k < NWB; k++) begin
        if (wb_valid[k] && (wb_addr[k*AW +: AW] == AW'(r))) clr[r] = 1'b1;
      end
    end
  end

  // A writeback landing this cycle already counts as clean; r0 is never set.
  assign eff_busy = sb_busy & ~clr;

  assign src1_ok  = !head.src1_used || !eff_busy[head.src1];
  assign src2_ok  = !head.src2_used || !eff_busy[head.src2];
  assign dest_ok  = !head.dest_used || !eff_busy[head.dest];
  assign fence_ok = !head.fence || (exe_idle && (eff_busy == '0));

  // Unit indices past NUNITS match nothing, so such an op only leaves by flush.
  always_comb begin
    unit_ok = 1'b0;
    for (int u = 0; u < NUNITS; u++) begin
      if (head.unit == UW'(u)) unit_ok = unit_ready[u];
    end
  end

  assign fire = (count != '0) && !flush && src1_ok && src2_ok && dest_ok
                && unit_ok && fence_ok;

  always_comb begin
    set_vec = '0;
    if (fire && head.dest_used) set_vec[head.dest] = 1'b1;
  end

  // Set-by-issue is OR'd after the clear so a new writer wins over the old writer's writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_busy <= '0;
    else        sb_busy <= {eff_busy[NREGS-1:1] | set_vec[NREGS-1:1], 1'b0};
  end

  assign out_valid     = fire;
  assign out_unit      = head.unit;
  assign out_dest      = head.dest;
  assign out_src1      = head.src1;
  assign out_src2      = head.src2;
  assign out_payload   = head.payload;
  assign out_dest_used = head.dest_used;

endmodule

// File: doc/issue_queue_m2.md
# issue_queue_m2

Parametrised in-order issue stage: a DEPTH-entry issue buffer in front of a register scoreboard. Decoded micro-ops sit between decode and the execution units (ALU/MUL/DIV/BRH/LSU). The head op is released to its target unit only when its sources are clean, its destination has no pending writer, and the unit accepts. Replaces the single-slot stall-based issue with buffering, multi-port writeback tracking and fence draining.

## Interface
Parameters:
- AW, 4: register address width; NREGS = 2**AW, register 0 hardwired clean.
- DEPTH, 4: buffer entries; power of two, ≥2.
- NWB, 2: writeback ports clearing scoreboard bits.
- NUNITS, 5: execution units; UW = $clog2(NUNITS).
- PW, 32: opaque payload width (inst bits, pc, uop flags) carried unchanged.

Ports:
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all buffered ops.
- in_valid  in  1  op offered by decode.
- in_ready  out  1  buffer can accept; = (count != DEPTH).
- in_dest / in_src1 / in_src2  in  AW each  register addresses.
- in_dest_used / in_src1_used / in_src2_used  in  1 each  field qualifiers.
- in_fence  in  1  op must issue into an idle machine.
- in_unit  in  UW  target unit index.
- in_payload  in  PW  opaque.
- wb_valid  in  NWB  per-port writeback strobe.
- wb_addr  in  NWB*AW  per-port writeback register, port k at [k*AW +: AW].
- unit_ready  in  NUNITS  unit can take an op this cycle.
- exe_idle  in  1  all units and writeback empty.
- out_valid  out  1  head issues this cycle (fire).
- out_unit / out_dest / out_src1 / out_src2 / out_payload  out  head fields, valid when out_valid.
- out_dest_used  out  1  head dest qualifier.
- sb_busy  out  NREGS  scoreboard vector; bit 0 always 0.
- count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Enqueue: in_valid && in_ready && !flush writes the tail entry and advances tail. Pointers wrap modulo DEPTH.
- Clear(r): true if any wb_valid[k] with wb_addr[k]==r. A busy bit being cleared this cycle counts as clean (same-cycle bypass).
- Head issue condition (fire), all required:
  - count>0 and !flush.
  - For each used source s with s!=0: !sb_busy[s] || clear(s).
  - Destination (WAW): same rule applied to the used dest when dest!=0.
  - unit_ready[head.unit].
  - If head.fence: exe_idle and sb_busy has no bits set other than ones being cleared this cycle.
- On fire: head pointer advances; sb_busy[dest] is set if dest_used and dest!=0.
- Scoreboard update priority per bit: set-by-issue wins over clear-by-wb in the same cycle. The old writer's wb and the new issue coincide legally.
- Out-of-range in_unit (≥NUNITS): treated as never ready. The op blocks, and the queue drains only by flush.
- Flush: count→0, head=tail=0 next cycle. No enqueue or issue in the flush cycle. The scoreboard is NOT cleared, because already-issued ops still write back.
- Simultaneous enqueue and fire: count unchanged, both pointers advance.

## Timing
- Reset (rst_n low, async): head=tail=count=0, sb_busy=0, in_ready=1, out_valid=0. Buffer contents don't-care. Reset mid-operation drops all ops and pending bits.
- Enqueue at edge t gives the earliest fire in cycle t+1. There is no empty-queue bypass.
- out_valid and all out_* are combinational from registered state plus wb_valid, wb_addr, unit_ready and exe_idle. There is no input-to-output path from in_*.
- Throughput: one issue per cycle when hazard-free.
- in_ready depends only on registered count. A full buffer does not accept on the cycle it frees a slot.

## Structure
- Shared package Types_m1 gains the unit index constants UNIT_ALU=0, UNIT_MUL=1, UNIT_DIV=2, UNIT_BRH=3, UNIT_LSU=4, plus a packed iq_entry_t struct holding dest, src1, src2, the three used flags, fence, unit and payload.
- Sub-module issue_fifo_m2 is the circular buffer: pointers, count, push/pop/flush, head read. issue_queue_m2 holds the scoreboard and the hazard and fire logic.

## Test plan
- RAW: op A (dest r3, ALU) then op B (src1 r3), unit_ready all 1. A fires at cycle 1 and sb_busy[3]=1. B is held, then fires in the same cycle wb_valid[0]=1 with wb_addr=3.
- WAW plus set-wins: r5 busy; op with dest r5 arrives while wb_valid[1]=1 and wb_addr=5. The op fires and sb_busy[5] stays 1 the next cycle.
- Full and backpressure: unit_ready=0, enqueue 4 ops, giving count=4 and in_ready=0. Raise unit_ready: fires occur on 4 consecutive cycles and in_ready returns to 1 after the first.
- Flush: 3 ops queued with sb_busy[2]=1; pulse flush. Next cycle count=0 and out_valid=0, and sb_busy[2] is still 1.
- Fence: r7 busy, fence op at head, exe_idle=1 → no fire. wb clears r7 → fire that cycle.
- r0 and reset: an op with dest r0 fires and sb_busy stays 0. Assert rst_n low mid-stream: count, sb_busy and out_valid go to 0 immediately (async).
